// File: rtl/reg_file_pkg.sv
// Shared widths, types and the write-hit helper for the multi-port register file.
package reg_file_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;

    typedef logic [DATA_W_DEF-1:0] reg_data_t;
    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

    // Addresses are passed zero-extended so one helper serves every ADDR_W.
    function automatic logic wr_hit(input logic [31:0] addr,
                                    input logic        we0,
                                    input logic [31:0] wa0,
                                    input logic        we1,
                                    input logic [31:0] wa1);
        return (we0 && (wa0 == addr)) || (we1 && (wa1 == addr));
    endfunction
endpackage

// File: rtl/reg_file_mp_rf_read_port.sv
// One combinational read port: decode, write bypass, R0 masking and busy lookup.
module rf_read_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic [ADDR_W-1:0]                  ra,
    input  logic [2**ADDR_W-1:0][DATA_W-1:0]   regs,
    input  logic [2**ADDR_W-1:0]               busy,
    input  logic                               we0,
    input  logic [ADDR_W-1:0]                  wa0,
    input  logic [DATA_W-1:0]                  wd0,
    input  logic                               we1,
    input  logic [ADDR_W-1:0]                  wa1,
    input  logic [DATA_W-1:0]                  wd1,
    input  logic                               busy_set,
    input  logic [ADDR_W-1:0]                  busy_wa,
    output logic [DATA_W-1:0]                  rd,
    output logic                               busy_rd
);
    logic hit;
    logic hit1;

    always_comb begin
        hit     = wr_hit(32'(ra), we0, 32'(wa0), we1, 32'(wa1));
        hit1    = wr_hit(32'(ra), 1'b0, 32'(wa0), we1, 32'(wa1));
        rd      = regs[ra];
        busy_rd = busy[ra];
        if (BYPASS != 0 && hit) begin
            rd = hit1 ? wd1 : wd0;
            // A simultaneous busy_set on the same register keeps it pending.
            if (!(busy_set && busy_wa == ra))
                busy_rd = 1'b0;
        end
        if (ZERO_REG != 0 && ra == '0)
            rd = '0;
    end
endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: two write ports, NR read ports, busy scoreboard, cpu_out mirror.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NR       = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0,
    parameter int OUT_IDX  = 2**ADDR_W - 1
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic [NR-1:0][ADDR_W-1:0]    ra,
    output logic [NR-1:0][DATA_W-1:0]    rd,
    output logic [NR-1:0]                busy_rd,
    input  logic                         we0,
    input  logic [ADDR_W-1:0]            wa0,
    input  logic [DATA_W-1:0]            wd0,
    input  logic                         we1,
    input  logic [ADDR_W-1:0]            wa1,
    input  logic [DATA_W-1:0]            wd1,
    input  logic                         busy_set,
    input  logic [ADDR_W-1:0]            busy_wa,
    output logic [DATA_W-1:0]            cpu_out,
    output logic                         cpu_out_stb
);
    localparam int                DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] OUT_A = ADDR_W'(OUT_IDX);

    if (ZERO_REG != 0 && OUT_IDX == 0) begin : g_bad_cfg
        $error("reg_file_mp: OUT_IDX must not be 0 when ZERO_REG is set");
    end

    logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [DEPTH-1:0]             busy_q, busy_d;
    logic [DATA_W-1:0]            cpu_out_q, cpu_out_d;
    logic                         stb_q, stb_d;
    logic                         we0_e, we1_e, bset_e;

    always_comb begin
        // Effective enables: nothing lands during reset or on a hardwired R0.
        we0_e  = RST_N && we0 && !(ZERO_REG != 0 && wa0 == '0);
        we1_e  = RST_N && we1 && !(ZERO_REG != 0 && wa1 == '0);
        bset_e = RST_N && busy_set && !(ZERO_REG != 0 && busy_wa == '0);

        regs_d = regs_q;
        if (we0_e) regs_d[wa0] = wd0;
        if (we1_e) regs_d[wa1] = wd1;

        busy_d = busy_q;
        for (int a = 0; a < DEPTH; a++)
            if (wr_hit(a, we0_e, 32'(wa0), we1_e, 32'(wa1)))
                busy_d[a] = 1'b0;
        if (bset_e) busy_d[busy_wa] = 1'b1;

        cpu_out_d = regs_d[OUT_A];
        stb_d     = wr_hit(32'(OUT_A), we0_e, 32'(wa0), we1_e, 32'(wa1));
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            regs_q    <= '0;
            busy_q    <= '0;
            cpu_out_q <= '0;
            stb_q     <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            busy_q    <= busy_d;
            cpu_out_q <= cpu_out_d;
            stb_q     <= stb_d;
        end
    end

    assign cpu_out     = cpu_out_q;
    assign cpu_out_stb = stb_q;

    for (genvar i = 0; i < NR; i++) begin : g_rp
        rf_read_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .BYPASS  (BYPASS),
            .ZERO_REG(ZERO_REG)
        ) u_rp (
            .ra      (ra[i]),
            .regs    (regs_q),
            .busy    (busy_q),
            .we0     (we0_e),
            .wa0     (wa0),
            .wd0     (wd0),
            .we1     (we1_e),
            .wa1     (wa1),
            .wd1     (wd1),
            .busy_set(bset_e),
            .busy_wa (busy_wa),
            .rd      (rd[i]),
            .busy_rd (busy_rd[i])
        );
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: two configurations (bypass/no-R0, no-bypass/R0) against an array model.
module tb_reg_file_mp;
    logic            CLK = 1'b0;
    logic            RST_N;
    logic [1:0][3:0] ra;
    logic            we0, we1, busy_set;
    logic [3:0]      wa0, wa1, busy_wa;
    logic [7:0]      wd0, wd1;

    logic [1:0][7:0] rd_a, rd_b;
    logic [1:0]      br_a, br_b;
    logic [7:0]      out_a, out_b;
    logic            stb_a, stb_b;

    int n_vec  = 0;
    int n_miss = 0;
    bit chk_en = 1'b0;

    always #5 CLK = ~CLK;

    reg_file_mp #(.DATA_W(8), .ADDR_W(4), .NR(2), .BYPASS(1), .ZERO_REG(0), .OUT_IDX(15)) dut_a (
        .CLK(CLK), .RST_N(RST_N), .ra(ra), .rd(rd_a), .busy_rd(br_a),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .busy_set(busy_set), .busy_wa(busy_wa), .cpu_out(out_a), .cpu_out_stb(stb_a));

    reg_file_mp #(.DATA_W(8), .ADDR_W(4), .NR(2), .BYPASS(0), .ZERO_REG(1), .OUT_IDX(15)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .ra(ra), .rd(rd_b), .busy_rd(br_b),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .busy_set(busy_set), .busy_wa(busy_wa), .cpu_out(out_b), .cpu_out_stb(stb_b));

    // Model state, index 0 = dut_a config, 1 = dut_b config.
    logic [7:0] m_reg [2][16];
    bit         m_busy[2][16];
    logic [7:0] m_out [2];
    bit         m_stb [2];

    function automatic bit byp(int c); return c == 0; endfunction
    function automatic bit zro(int c); return c == 1; endfunction

    function automatic bit wen(int c, logic we, logic [3:0] wa);
        return RST_N && we && !(zro(c) && wa == 4'd0);
    endfunction

    function automatic logic [7:0] exp_rd(int c, logic [3:0] a);
        if (zro(c) && a == 4'd0) return 8'h00;
        if (byp(c)) begin
            if (wen(c, we1, wa1) && wa1 == a) return wd1;
            if (wen(c, we0, wa0) && wa0 == a) return wd0;
        end
        return m_reg[c][a];
    endfunction

    function automatic bit exp_busy(int c, logic [3:0] a);
        if (byp(c) && ((wen(c, we0, wa0) && wa0 == a) || (wen(c, we1, wa1) && wa1 == a))
                   && !(wen(c, busy_set, busy_wa) && busy_wa == a))
            return 1'b0;
        return m_busy[c][a];
    endfunction

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int c = 0; c < 2; c++) begin
                for (int a = 0; a < 16; a++) begin
                    m_reg[c][a]  <= 8'h00;
                    m_busy[c][a] <= 1'b0;
                end
                m_out[c] <= 8'h00;
                m_stb[c] <= 1'b0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (wen(c, we0, wa0)) begin m_reg[c][wa0] <= wd0; m_busy[c][wa0] <= 1'b0; end
                if (wen(c, we1, wa1)) begin m_reg[c][wa1] <= wd1; m_busy[c][wa1] <= 1'b0; end
                if (wen(c, busy_set, busy_wa)) m_busy[c][busy_wa] <= 1'b1;
                m_stb[c] <= (wen(c, we0, wa0) && wa0 == 4'd15) || (wen(c, we1, wa1) && wa1 == 4'd15);
                m_out[c] <= (wen(c, we1, wa1) && wa1 == 4'd15) ? wd1 :
                            (wen(c, we0, wa0) && wa0 == 4'd15) ? wd0 : m_reg[c][15];
            end
        end
    end

    task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            for (int c = 0; c < 2; c++) begin
                for (int p = 0; p < 2; p++) begin
                    chk($sformatf("model rd c%0d p%0d", c, p),
                        c == 0 ? rd_a[p] : rd_b[p], exp_rd(c, ra[p]));
                    chk($sformatf("model busy_rd c%0d p%0d", c, p),
                        {7'b0, c == 0 ? br_a[p] : br_b[p]}, {7'b0, exp_busy(c, ra[p])});
                end
                chk($sformatf("model cpu_out c%0d", c), c == 0 ? out_a : out_b, m_out[c]);
                chk($sformatf("model stb c%0d", c), {7'b0, c == 0 ? stb_a : stb_b}, {7'b0, m_stb[c]});
            end
        end
    end

    task automatic nxt; @(posedge CLK); #1; endtask
    task automatic mid; @(negedge CLK); endtask
    task automatic idle; we0 = 0; we1 = 0; busy_set = 0; endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        RST_N = 1'b0; ra = '0; wa0 = '0; wa1 = '0; busy_wa = '0; wd0 = '0; wd1 = '0;
        idle();
        nxt; nxt;
        chk_en = 1'b1;
        chk("reset cpu_out", out_a, 8'h00);
        chk("reset rd", rd_a[0], 8'h00);
        RST_N = 1'b1;

        // Fill R1..R15 through port 0.
        for (int i = 1; i < 16; i++) begin
            we0 = 1; wa0 = 4'(i); wd0 = 8'(i * 17);
            nxt;
        end
        idle();
        mid;
        chk("fill cpu_out", out_a, 8'hFF);
        chk("fill stb pulse", {7'b0, stb_a}, 8'h01);
        nxt; mid;
        chk("fill stb drop", {7'b0, stb_a}, 8'h00);
        for (int i = 1; i < 16; i++) begin
            ra[0] = 4'(i); ra[1] = 4'(16 - i);
            #1;
            chk($sformatf("readback R%0d", i), rd_a[0], 8'(i * 17));
            chk($sformatf("readback b R%0d", 16 - i), rd_b[1], 8'(((16 - i) * 17)));
        end

        // Dual write to the same register: load port wins.
        nxt;
        ra[0] = 4'd5; we0 = 1; wa0 = 4'd5; wd0 = 8'hAA; we1 = 1; wa1 = 4'd5; wd1 = 8'h55;
        mid;
        chk("conflict bypass", rd_a[0], 8'h55);
        nxt; idle(); mid;
        chk("conflict stored a", rd_a[0], 8'h55);
        chk("conflict stored b", rd_b[0], 8'h55);

        // Read-during-write without bypass sees the old value first.
        nxt;
        ra[0] = 4'd3; we0 = 1; wa0 = 4'd3; wd0 = 8'h3C;
        mid;
        chk("nobypass old", rd_b[0], 8'h33);
        chk("bypass new", rd_a[0], 8'h3C);
        nxt; idle(); mid;
        chk("nobypass new", rd_b[0], 8'h3C);

        // Scoreboard set / clear / set-wins.
        nxt;
        ra[0] = 4'd7; busy_set = 1; busy_wa = 4'd7;
        mid;
        chk("busy before edge", {7'b0, br_a[0]}, 8'h00);
        nxt;
        busy_set = 0; we0 = 1; wa0 = 4'd7; wd0 = 8'h12;
        mid;
        chk("busy bypass clear a", {7'b0, br_a[0]}, 8'h00);
        chk("busy held b", {7'b0, br_b[0]}, 8'h01);
        nxt; idle(); mid;
        chk("busy cleared", {7'b0, br_b[0]}, 8'h00);
        chk("R7 written", rd_a[0], 8'h12);
        nxt;
        busy_set = 1; busy_wa = 4'd7; we0 = 1; wa0 = 4'd7; wd0 = 8'h34;
        nxt; idle(); mid;
        chk("set wins a", {7'b0, br_a[0]}, 8'h01);
        chk("set wins b", {7'b0, br_b[0]}, 8'h01);

        // R0 writes and busy_set: dropped only in the ZERO_REG instance.
        nxt;
        ra[0] = 4'd0; we0 = 1; wa0 = 4'd0; wd0 = 8'hFF; busy_set = 1; busy_wa = 4'd0;
        mid;
        chk("zero rd same", rd_b[0], 8'h00);
        nxt; idle(); mid;
        chk("zero rd", rd_b[0], 8'h00);
        chk("zero busy", {7'b0, br_b[0]}, 8'h00);
        chk("nonzero R0 rd", rd_a[0], 8'hFF);
        chk("nonzero R0 busy", {7'b0, br_a[0]}, 8'h01);

        // Load-port write to the mirrored register.
        nxt;
        we1 = 1; wa1 = 4'd15; wd1 = 8'h5A;
        nxt; idle(); mid;
        chk("load cpu_out", out_a, 8'h5A);
        chk("load stb", {7'b0, stb_a}, 8'h01);

        // Random traffic, checked by the model process.
        for (int k = 0; k < 300; k++) begin
            nxt;
            ra[0] = 4'($urandom_range(15)); ra[1] = 4'($urandom_range(15));
            we0 = 1'($urandom); wa0 = 4'($urandom_range(15)); wd0 = 8'($urandom);
            we1 = 1'($urandom); wa1 = 4'($urandom_range(15)); wd1 = 8'($urandom);
            busy_set = 1'($urandom); busy_wa = 4'($urandom_range(15));
            if (k % 4 == 0) wa1 = wa0;
        end

        // Asynchronous reset in the middle of a cycle with writes pending.
        nxt;
        ra[0] = 4'd15; ra[1] = 4'd2;
        we0 = 1; wa0 = 4'd15; wd0 = 8'h77; we1 = 1; wa1 = 4'd2; wd1 = 8'h99;
        busy_set = 1; busy_wa = 4'd2;
        #2 RST_N = 1'b0;
        #1;
        chk("async rd0 a", rd_a[0], 8'h00);
        chk("async rd1 a", rd_a[1], 8'h00);
        chk("async rd1 b", rd_b[1], 8'h00);
        chk("async busy a", {6'b0, br_a}, 8'h00);
        chk("async cpu_out", out_a, 8'h00);
        chk("async stb", {7'b0, stb_a}, 8'h00);
        nxt;
        idle();
        RST_N = 1'b1;
        mid;
        chk("post reset R15", rd_a[0], 8'h00);
        nxt; mid;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
